// File: rtl/dmem_pingpong_ctrl.sv
// Ping-pong data-memory controller: fills bank ~rb from a valid/ready write stream
// while draining bank rb into a valid/ready read stream. Optional macro: DMEM_CTRL_LAST_EN (adds out_last).
module dmem_pingpong_ctrl #(
  parameter int BITS = 32,
  parameter int ADDR = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ADDR-2:0] cfg_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
`ifdef DMEM_CTRL_LAST_EN
  output logic            out_last,
`endif
  output logic            mem_cen,
  output logic            mem_gwen,
  output logic [ADDR-1:0] mem_addr_r,
  output logic [ADDR-1:0] mem_addr_w,
  output logic [BITS-1:0] mem_data_i,
  input  logic [BITS-1:0] mem_data_o
);

  localparam int PW = ADDR - 1;

  logic            r_rb;
  logic [1:0]      r_full;
  logic [PW-1:0]   r_len [2];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_lastAddrW;
  logic [BITS-1:0] r_lastData;
  logic            r_inflight;
  logic [BITS-1:0] r_fifo [2];
  logic            r_fifoRd;
  logic            r_fifoWr;
  logic [1:0]      r_occ;

  logic            w_wb;
  logic [PW-1:0]   w_wrLen;
  logic            w_wrFire;
  logic            w_wrLast;
  logic            w_fifoNonEmpty;
  logic            w_outValid;
  logic            w_pop;
  logic [2:0]      w_level;
  logic            w_rdIssue;
  logic            w_rdLast;
  logic            w_swap;
  logic            w_push;
  logic            w_fifoPop;

  // Frame length is taken live from cfg_len on the first word, then from the latched copy.
  assign w_wb      = ~r_rb;
  assign w_wrLen   = (r_wptr == '0) ? cfg_len : r_len[w_wb];
  assign in_ready  = !rst && !r_full[w_wb];
  assign w_wrFire  = in_valid && in_ready;
  assign w_wrLast  = w_wrFire && (r_wptr == w_wrLen);

  assign w_fifoNonEmpty = (r_occ != 2'd0);
  assign w_outValid     = w_fifoNonEmpty || r_inflight;
  assign w_pop          = w_outValid && out_ready;
  assign w_level        = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rdIssue      = !rst && r_full[r_rb] && (w_level < 3'd2);
  assign w_rdLast       = w_rdIssue && (r_rptr == r_len[r_rb]);
  assign w_swap         = !rst && r_full[w_wb] && !r_full[r_rb];

  // A returning word bypasses the FIFO when it is empty and the consumer takes it at once.
  assign w_push    = r_inflight && !(w_pop && !w_fifoNonEmpty);
  assign w_fifoPop = w_pop && w_fifoNonEmpty;

  assign out_valid  = w_outValid;
  assign out_data   = w_fifoNonEmpty ? r_fifo[r_fifoRd] : (r_inflight ? mem_data_o : '0);
  assign mem_cen    = !(w_wrFire || w_rdIssue);
  assign mem_gwen   = 1'b1;
  assign mem_addr_r = {r_rb, r_rptr};
  // Idle write port repeats the last write so the forced rewrite is harmless.
  assign mem_addr_w = {w_wb, (w_wrFire ? r_wptr : r_lastAddrW)};
  assign mem_data_i = w_wrFire ? in_data : r_lastData;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rb        <= 1'b0;
      r_full      <= 2'b00;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_lastAddrW <= '0;
      r_lastData  <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_fifoRd    <= 1'b0;
      r_fifoWr    <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      if (w_wrFire) begin
        r_lastAddrW <= r_wptr;
        r_lastData  <= in_data;
        if (r_wptr == '0) r_len[w_wb] <= cfg_len;
        if (w_wrLast) begin
          r_wptr       <= '0;
          r_full[w_wb] <= 1'b1;
        end else begin
          r_wptr <= r_wptr + PW'(1);
        end
      end
      if (w_rdIssue) begin
        if (w_rdLast) begin
          r_rptr       <= '0;
          r_full[r_rb] <= 1'b0;
        end else begin
          r_rptr <= r_rptr + PW'(1);
        end
      end
      if (w_swap) r_rb <= ~r_rb;
      r_inflight <= w_rdIssue;
      if (w_push) begin
        r_fifo[r_fifoWr] <= mem_data_o;
        r_fifoWr         <= ~r_fifoWr;
      end
      if (w_fifoPop) r_fifoRd <= ~r_fifoRd;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_fifoPop};
    end
  end

`ifdef DMEM_CTRL_LAST_EN
  logic r_inflightLast;
  logic r_fifoLast [2];

  // The last-word marker follows the same path as its data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflightLast <= 1'b0;
      r_fifoLast[0]  <= 1'b0;
      r_fifoLast[1]  <= 1'b0;
    end else begin
      r_inflightLast <= w_rdLast;
      if (w_push) r_fifoLast[r_fifoWr] <= r_inflightLast;
    end
  end

  assign out_last = w_fifoNonEmpty ? r_fifoLast[r_fifoRd] : (r_inflight && r_inflightLast);
`endif

endmodule
